// File: rtl/mask_unit_read_pipe.sv
// mask_unit_read_pipe: credit-gated VRF read pipe for one crossbar output port.
// A request is forwarded to the VRF read port. Its tag {writeIndex, dataOffset}
// travels through a fixed-latency shift pipeline alongside the read. When the
// tag reaches the end of that pipeline, the VRF result and the tag are captured
// together into an in-order response FIFO. The credit counter reserves a FIFO
// slot for every request before it is issued, so the FIFO can never overflow.
//
// Handshakes use strict valid/ready semantics. A transfer happens on a rising
// clock edge where valid and ready are both high. Once valid is raised, neither
// side may make it depend on the other side's ready in a way that forms a loop.
// enq_ready and vrfRead_valid depend only on the local credit, never on deq_ready.
module mask_unit_read_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [4:0]            enq_bits_vs,
  input  logic [7:0]            enq_bits_offset,
  input  logic [1:0]            enq_bits_writeIndex,
  input  logic [1:0]            enq_bits_dataOffset,
  output logic                  vrfRead_valid,
  input  logic                  vrfRead_ready,
  output logic [4:0]            vrfRead_bits_vs,
  output logic [7:0]            vrfRead_bits_offset,
  input  logic [DATA_WIDTH-1:0] vrfReadResult,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_bits_data,
  output logic [1:0]            deq_bits_writeIndex,
  output logic [1:0]            deq_bits_dataOffset
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH + 1);
  localparam int TagW = 4;

  logic [CntW-1:0]            credit;
  logic                       creditOk;
  logic                       fire;
  logic                       deqFire;
  logic                       fifoWrite;
  logic [LATENCY-1:0]         pipeValid;
  logic [TagW-1:0]            pipeTag [LATENCY];
  logic [DATA_WIDTH+TagW-1:0] fifoMem [DEPTH];
  logic [DATA_WIDTH+TagW-1:0] fifoHead;
  logic [PtrW-1:0]            wrPtr;
  logic [PtrW-1:0]            rdPtr;
  logic [CntW-1:0]            fifoCount;

  // Reset forces the credit view to "full". This keeps enq_ready equal to
  // vrfRead_ready while reset is held, even on the first reset cycle.
  assign creditOk            = reset | (credit != '0);
  assign vrfRead_valid       = enq_valid & creditOk;
  assign enq_ready           = vrfRead_ready & creditOk;
  assign vrfRead_bits_vs     = enq_bits_vs;
  assign vrfRead_bits_offset = enq_bits_offset;
  assign fire                = enq_valid & enq_ready;

  assign deq_valid           = ~reset & (fifoCount != '0);
  assign deqFire             = deq_valid & deq_ready;
  assign fifoWrite           = pipeValid[LATENCY-1];

  assign fifoHead            = fifoMem[rdPtr];
  assign deq_bits_data       = fifoHead[DATA_WIDTH+TagW-1:TagW];
  assign deq_bits_writeIndex = fifoHead[3:2];
  assign deq_bits_dataOffset = fifoHead[1:0];

  // Credit counter: an issued request takes a credit, and a dequeued response returns it.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit <= CntW'(DEPTH);
    end else if (fire && !deqFire) begin
      credit <= credit - CntW'(1);
    end else if (!fire && deqFire) begin
      credit <= credit + CntW'(1);
    end
  end

  // Valid bits of the latency pipeline. These are cleared by reset, so late VRF data is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipeValid <= '0;
    end else begin
      pipeValid[0] <= fire;
      for (int i = 1; i < LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
      end
    end
  end

  // Tag payload of the latency pipeline. It is qualified by pipeValid, so it needs no reset.
  always_ff @(posedge clock) begin
    pipeTag[0] <= {enq_bits_writeIndex, enq_bits_dataOffset};
    for (int i = 1; i < LATENCY; i++) begin
      pipeTag[i] <= pipeTag[i-1];
    end
  end

  // FIFO storage: capture the VRF data with the tag that arrives at the pipeline tail.
  always_ff @(posedge clock) begin
    if (fifoWrite) begin
      fifoMem[wrPtr] <= {vrfReadResult, pipeTag[LATENCY-1]};
    end
  end

  // FIFO pointers wrap modulo DEPTH. Occupancy is tracked separately as 0..DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (fifoWrite) begin
        wrPtr <= (wrPtr == PtrW'(DEPTH - 1)) ? '0 : wrPtr + PtrW'(1);
      end
      if (deqFire) begin
        rdPtr <= (rdPtr == PtrW'(DEPTH - 1)) ? '0 : rdPtr + PtrW'(1);
      end
      if (fifoWrite && !deqFire) begin
        fifoCount <= fifoCount + CntW'(1);
      end else if (!fifoWrite && deqFire) begin
        fifoCount <= fifoCount - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mask_unit_read_pipe.sv
// tb_mask_unit_read_pipe: directed scenarios plus a long random run.
// The reference model is transaction level. A queue of outstanding requests
// records each request's tag and issue cycle. A queue of responses records each
// response's data and the cycle its data arrived.
module tb_mask_unit_read_pipe;

  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enq_valid;
  logic          enq_ready;
  logic [4:0]    enq_bits_vs;
  logic [7:0]    enq_bits_offset;
  logic [1:0]    enq_bits_writeIndex;
  logic [1:0]    enq_bits_dataOffset;
  logic          vrfRead_valid;
  logic          vrfRead_ready;
  logic [4:0]    vrfRead_bits_vs;
  logic [7:0]    vrfRead_bits_offset;
  logic [DW-1:0] vrfReadResult;
  logic          deq_valid;
  logic          deq_ready;
  logic [DW-1:0] deq_bits_data;
  logic [1:0]    deq_bits_writeIndex;
  logic [1:0]    deq_bits_dataOffset;

  // Clock and reset request
  always #5 clock = ~clock;
  logic rst_req = 1'b1;

  mask_unit_read_pipe #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_bits_vs(enq_bits_vs), .enq_bits_offset(enq_bits_offset),
    .enq_bits_writeIndex(enq_bits_writeIndex), .enq_bits_dataOffset(enq_bits_dataOffset),
    .vrfRead_valid(vrfRead_valid), .vrfRead_ready(vrfRead_ready),
    .vrfRead_bits_vs(vrfRead_bits_vs), .vrfRead_bits_offset(vrfRead_bits_offset),
    .vrfReadResult(vrfReadResult),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_bits_data(deq_bits_data), .deq_bits_writeIndex(deq_bits_writeIndex),
    .deq_bits_dataOffset(deq_bits_dataOffset)
  );

  typedef struct { logic [3:0] tag; int fcyc; } pend_t;
  typedef struct { logic [DW-1:0] data; logic [3:0] tag; int wcyc; } resp_t;

  pend_t pend_q[$];
  resp_t exp_q[$];
  int    cyc    = 0;
  int    total  = 0;
  int    bad    = 0;
  int    n_resp = 0;
  int    n_fire = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Driver: apply one cycle of inputs just after the edge, then return at the falling edge.
  task automatic step(input logic ev, input logic [4:0] vs, input logic [7:0] off,
                      input logic [1:0] wi, input logic [1:0] dof, input logic vr,
                      input logic dr, input logic [DW-1:0] rd);
    @(posedge clock);
    #1;
    reset               = rst_req;
    enq_valid           = ev;
    enq_bits_vs         = vs;
    enq_bits_offset     = off;
    enq_bits_writeIndex = wi;
    enq_bits_dataOffset = dof;
    vrfRead_ready       = vr;
    deq_ready           = dr;
    vrfReadResult       = rd;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 8'd0, 2'd0, 2'd0, 1'b1, dr, $urandom);
  endtask

  // Scoreboard and reference model, evaluated once per cycle at the falling edge.
  always @(negedge clock) begin : monitor
    int    credit;
    logic  exp_dv;
    pend_t p;
    resp_t r;
    cyc++;
    if (reset) begin
      check_val("rst_deq_valid", 32'(deq_valid), 32'd0);
      check_val("rst_enq_ready", 32'(enq_ready), 32'(vrfRead_ready));
      pend_q.delete();
      exp_q.delete();
    end else begin
      credit = DEPTH - pend_q.size() - exp_q.size();
      check_val("enq_ready", 32'(enq_ready), 32'(vrfRead_ready && credit != 0));
      check_val("vrf_valid", 32'(vrfRead_valid), 32'(enq_valid && credit != 0));
      check_val("vrf_addr", {19'd0, vrfRead_bits_vs, vrfRead_bits_offset},
                {19'd0, enq_bits_vs, enq_bits_offset});
      exp_dv = (exp_q.size() > 0) && (exp_q[0].wcyc < cyc);
      check_val("deq_valid", 32'(deq_valid), 32'(exp_dv));
      if (deq_valid && deq_ready && exp_dv) begin
        r = exp_q.pop_front();
        check_val("deq_data", deq_bits_data, r.data);
        check_val("deq_tag", {28'd0, deq_bits_writeIndex, deq_bits_dataOffset}, {28'd0, r.tag});
        n_resp++;
      end
      if (pend_q.size() > 0 && pend_q[0].fcyc + LAT == cyc) begin
        p = pend_q.pop_front();
        r.data = vrfReadResult;
        r.tag  = p.tag;
        r.wcyc = cyc;
        exp_q.push_back(r);
      end
      if (enq_valid && enq_ready) begin
        p.tag  = {enq_bits_writeIndex, enq_bits_dataOffset};
        p.fcyc = cyc;
        pend_q.push_back(p);
        n_fire++;
      end
    end
  end

  initial begin
    int r0;
    int f0;
    reset = 1'b1; enq_valid = 1'b0; enq_bits_vs = '0; enq_bits_offset = '0;
    enq_bits_writeIndex = '0; enq_bits_dataOffset = '0; vrfRead_ready = 1'b1;
    deq_ready = 1'b0; vrfReadResult = '0;

    // Reset
    rst_req = 1'b1;
    idle(3, 1'b0);
    check_val("reset_deq_valid", 32'(deq_valid), 32'd0);
    rst_req = 1'b0;
    idle(1, 1'b0);

    // Single request, known data
    step(1'b1, 5'd3, 8'h10, 2'd2, 2'd1, 1'b1, 1'b0, $urandom);
    check_val("t1_fire", 32'(enq_ready), 32'd1);
    step(1'b0, 5'd0, 8'd0, 2'd0, 2'd0, 1'b1, 1'b0, $urandom);
    step(1'b0, 5'd0, 8'd0, 2'd0, 2'd0, 1'b1, 1'b0, 32'hDEADBEEF);
    check_val("t1_not_yet", 32'(deq_valid), 32'd0);
    step(1'b0, 5'd0, 8'd0, 2'd0, 2'd0, 1'b1, 1'b1, $urandom);
    check_val("t1_valid", 32'(deq_valid), 32'd1);
    check_val("t1_data", deq_bits_data, 32'hDEADBEEF);
    check_val("t1_wi", 32'(deq_bits_writeIndex), 32'd2);
    check_val("t1_doff", 32'(deq_bits_dataOffset), 32'd1);

    // Credit exhaustion with deq_ready low
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'(i), 8'(i), 2'(i), 2'(3 - i), 1'b1, 1'b0, $urandom);
      check_val("t2_fire", 32'(enq_ready), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd9, 8'd9, 2'd1, 2'd1, 1'b1, 1'b0, $urandom);
      check_val("t2_blocked_rdy", 32'(enq_ready), 32'd0);
      check_val("t2_blocked_vld", 32'(vrfRead_valid), 32'd0);
    end
    step(1'b1, 5'd9, 8'd9, 2'd1, 2'd1, 1'b1, 1'b1, $urandom);
    check_val("t2_deq_cycle", 32'(enq_ready), 32'd0);
    check_val("t2_deq_valid", 32'(deq_valid), 32'd1);
    step(1'b1, 5'd9, 8'd9, 2'd1, 2'd1, 1'b1, 1'b0, $urandom);
    check_val("t2_req5_fires", 32'(enq_ready), 32'd1);
    step(1'b0, 5'd0, 8'd0, 2'd0, 2'd0, 1'b1, 1'b0, $urandom);
    check_val("t2_credit_zero", 32'(enq_ready), 32'd0);
    idle(10, 1'b1);

    // Full FIFO, then a new request every cycle while draining
    r0 = n_resp;
    f0 = n_fire;
    for (int i = 0; i < 4; i++) step(1'b1, 5'd1, 8'd2, 2'(i), 2'(i), 1'b1, 1'b0, $urandom);
    idle(3, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 5'(i), 8'(i), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1, 1'b1, $urandom);
    idle(8, 1'b1);
    check_val("t3_no_loss", 32'(n_resp - r0), 32'(n_fire - f0));
    check_val("t3_at_least_8", 32'((n_resp - r0) >= 8), 32'd1);

    // VRF port busy holds the request
    step(1'b1, 5'd7, 8'd7, 2'd3, 2'd2, 1'b0, 1'b0, $urandom);
    check_val("t4_busy_rdy", 32'(enq_ready), 32'd0);
    check_val("t4_busy_vld", 32'(vrfRead_valid), 32'd1);
    step(1'b1, 5'd7, 8'd7, 2'd3, 2'd2, 1'b1, 1'b0, $urandom);
    check_val("t4_fire", 32'(enq_ready), 32'd1);
    idle(2, 1'b0);
    step(1'b0, 5'd0, 8'd0, 2'd0, 2'd0, 1'b1, 1'b1, $urandom);
    check_val("t4_resp", 32'(deq_valid), 32'd1);
    check_val("t4_wi", 32'(deq_bits_writeIndex), 32'd3);
    check_val("t4_doff", 32'(deq_bits_dataOffset), 32'd2);

    // Reset right after two requests drops them
    step(1'b1, 5'd1, 8'd1, 2'd1, 2'd1, 1'b1, 1'b0, $urandom);
    step(1'b1, 5'd2, 8'd2, 2'd2, 2'd2, 1'b1, 1'b0, $urandom);
    rst_req = 1'b1;
    step(1'b0, 5'd0, 8'd0, 2'd0, 2'd0, 1'b1, 1'b0, 32'hBAD0BAD0);
    rst_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 8'd0, 2'd0, 2'd0, 1'b1, 1'b1, 32'hBAD0BAD0);
      check_val("t5_no_resp", 32'(deq_valid), 32'd0);
      check_val("t5_credit", 32'(enq_ready), 32'd1);
    end

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      rst_req = ($urandom_range(0, 1999) == 0);
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) != 0, $urandom);
    end
    rst_req = 1'b0;
    idle(12, 1'b1);
    check_val("final_drained", 32'(deq_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
